// File: rtl/vec_add.sv
// Lane-wise signed fixed-point vector adder with per-lane overflow flags, 1-cycle latency.
// Define VEC_ADD_SAT_EN to saturate overflowing lanes; otherwise lanes wrap.
module vec_add #(
  parameter int unsigned ARR_WIDTH = 4,
  parameter int unsigned FXP_N     = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] in_1,
  input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] in_2,
  output logic                                 out_valid,
  output logic signed [ARR_WIDTH-1:0][FXP_N-1:0] sum_out,
  output logic        [ARR_WIDTH-1:0]          ovf
);

  localparam logic [FXP_N-1:0] MAX_POS = {1'b0, {(FXP_N-1){1'b1}}};
  localparam logic [FXP_N-1:0] MIN_NEG = {1'b1, {(FXP_N-1){1'b0}}};

  logic [ARR_WIDTH-1:0][FXP_N-1:0] raw_c;
  logic [ARR_WIDTH-1:0][FXP_N-1:0] sum_c;
  logic [ARR_WIDTH-1:0]            ovf_c;

  // Per-lane add; overflow when operand signs agree but the truncated sum's sign differs.
  always_comb begin
    raw_c = '0;
    sum_c = '0;
    ovf_c = '0;
    for (int unsigned i = 0; i < ARR_WIDTH; i++) begin
      raw_c[i] = in_1[i] + in_2[i];
      ovf_c[i] = (in_1[i][FXP_N-1] == in_2[i][FXP_N-1]) &&
                 (raw_c[i][FXP_N-1] != in_1[i][FXP_N-1]);
`ifdef VEC_ADD_SAT_EN
      sum_c[i] = ovf_c[i] ? (in_1[i][FXP_N-1] ? MIN_NEG : MAX_POS) : raw_c[i];
`else
      sum_c[i] = raw_c[i];
`endif
    end
  end

  // Result register: updates only on valid input, holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum_out   <= '0;
      ovf       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_out <= sum_c;
        ovf     <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_vec_add.sv
// Scoreboard bench for vec_add: driver queues expected results, monitor pops on out_valid.
module tb_vec_add;

  localparam int unsigned AW = 4;
  localparam int unsigned N  = 16;
  localparam longint MAXV = (64'sd1 <<< (N-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (N-1));

  typedef logic [AW-1:0][N-1:0] vec_t;
  typedef struct packed {
    vec_t          s;
    logic [AW-1:0] o;
  } exp_t;

  logic clock = 1'b0;
  logic reset, in_valid, out_valid;
  vec_t in_1, in_2, sum_out;
  logic [AW-1:0] ovf;

  exp_t q[$];
  vec_t hold_s;
  logic [AW-1:0] hold_o;
  int tests = 0;
  int fails = 0;
  bit done = 1'b0;

  vec_add #(.ARR_WIDTH(AW), .FXP_N(N)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_1(in_1), .in_2(in_2),
    .out_valid(out_valid), .sum_out(sum_out), .ovf(ovf)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input int l3, input int l2, input int l1, input int l0);
    vec_t v;
    v[3] = 16'(l3);
    v[2] = 16'(l2);
    v[1] = 16'(l1);
    v[0] = 16'(l0);
    return v;
  endfunction

  // Reference: exact integer sum, then clamp or reduce modulo 2^N.
  function automatic exp_t model(input vec_t a, input vec_t b);
    exp_t e;
    longint x;
    for (int i = 0; i < int'(AW); i++) begin
      x = longint'($signed(a[i])) + longint'($signed(b[i]));
      e.o[i] = (x > MAXV) || (x < MINV);
`ifdef VEC_ADD_SAT_EN
      if (x > MAXV) x = MAXV;
      else if (x < MINV) x = MINV;
`endif
      e.s[i] = x[N-1:0];
    end
    return e;
  endfunction

  function automatic logic [N-1:0] rnd_lane();
    case ($urandom_range(0, 4))
      0: return 16'h7fff;
      1: return 16'h8000;
      2: return 16'($signed(7'($urandom)));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic r, input logic v, input vec_t a, input vec_t b,
                       input logic use_fixed, input exp_t fixed);
    reset = r; in_valid = v; in_1 = a; in_2 = b;
    @(posedge clock);
    if (r) begin
      q.delete();
      hold_s = '0;
      hold_o = '0;
    end else if (v) begin
      q.push_back(use_fixed ? fixed : model(a, b));
    end
    #1;
  endtask

  task automatic send(input vec_t a, input vec_t b);
    drive(1'b0, 1'b1, a, b, 1'b0, '0);
  endtask

  task automatic send_exp(input vec_t a, input vec_t b, input vec_t es, input logic [AW-1:0] eo);
    exp_t e;
    e.s = es;
    e.o = eo;
    drive(1'b0, 1'b1, a, b, 1'b1, e);
  endtask

  task automatic idle(input logic r);
    drive(r, 1'b0, mk(5, 6, 7, 8), mk(1, 1, 1, 1), 1'b0, '0);
  endtask

  // Monitor: every falling edge checks valid, result on valid, hold otherwise.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clock);
      tests++;
      if (out_valid !== (q.size() > 0)) begin
        fails++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, q.size() > 0, $time);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        if (out_valid === 1'b1) begin
          tests++;
          if (sum_out !== e.s || ovf !== e.o) begin
            fails++;
            $display("FAIL result: got sum=%h ovf=%b expected sum=%h ovf=%b at %0t",
                     sum_out, ovf, e.s, e.o, $time);
          end
          hold_s = e.s;
          hold_o = e.o;
        end
      end else if (out_valid !== 1'b1) begin
        tests++;
        if (sum_out !== hold_s || ovf !== hold_o) begin
          fails++;
          $display("FAIL hold: got sum=%h ovf=%b expected sum=%h ovf=%b at %0t",
                   sum_out, ovf, hold_s, hold_o, $time);
        end
      end
    end
  end

  initial begin
    vec_t a, b;
    hold_s = '0;
    hold_o = '0;
    // Reset held two cycles with live nonzero inputs.
    drive(1'b1, 1'b1, mk(100, 200, 300, 400), mk(1, 2, 3, 4), 1'b0, '0);
    drive(1'b1, 1'b1, mk(-5, 6, -7, 8), mk(9, 9, 9, 9), 1'b0, '0);

    send_exp(mk(10, 20, 30, 40), mk(1, 2, 3, 4), mk(11, 22, 33, 44), 4'b0000);
    send_exp(mk(-10, -20, -30, -40), mk(-1, -2, -3, -4), mk(-11, -22, -33, -44), 4'b0000);
    send_exp(mk(10, -20, 30, -40), mk(-1, 2, -3, 4), mk(9, -18, 27, -36), 4'b0000);
`ifdef VEC_ADD_SAT_EN
    send_exp(mk(32767, -32768, 0, -1), mk(1, -1, 32767, -32768),
             mk(32767, -32768, 32767, -32768), 4'b1101);
`else
    send_exp(mk(32767, -32768, 0, -1), mk(1, -1, 32767, -32768),
             mk(-32768, 32767, 32767, 32767), 4'b1101);
`endif
    send_exp(mk(32767, -32768, 32767, -32768), mk(-32768, 32767, -32768, 32767),
             mk(-1, -1, -1, -1), 4'b0000);
    send_exp(mk(0, 0, 0, 0), mk(0, 0, 0, 0), mk(0, 0, 0, 0), 4'b0000);

    // Valid gating then mid-stream reset; a valid input on the reset edge is dropped.
    send_exp(mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(6, 8, 10, 12), 4'b0000);
    idle(1'b0);
    send_exp(mk(-3, 100, 7, 0), mk(3, -200, 7, 1), mk(0, -100, 14, 1), 4'b0000);
    drive(1'b1, 1'b1, mk(11, 11, 11, 11), mk(2, 2, 2, 2), 1'b0, '0);
    idle(1'b0);
    send_exp(mk(7, 7, 7, 7), mk(-8, 8, -8, 8), mk(-1, 15, -1, 15), 4'b0000);

    // Randomised traffic with gaps, back-to-back bursts and occasional resets.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < int'(AW); i++) begin
        a[i] = rnd_lane();
        b[i] = rnd_lane();
      end
      if ($urandom_range(0, 49) == 0)
        drive(1'b1, 1'b1, a, b, 1'b0, '0);
      else if ($urandom_range(0, 3) == 0)
        drive(1'b0, 1'b0, a, b, 1'b0, '0);
      else
        send(a, b);
    end

    idle(1'b0);
    idle(1'b0);
    @(negedge clock);
    done = 1'b1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
